// File: rtl/countdown_timer_pkg.sv
// Shared constants for the digital-clock countdown timer: field codes, limits and widths.
// The optional repeating mode is enabled by defining TIMER_RELOAD_EN.
package countdown_timer_pkg;

    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned HOUR_W = 5;

    localparam logic [1:0] SELECT_NONE = 2'd0;
    localparam logic [1:0] SELECT_SEC  = 2'd1;
    localparam logic [1:0] SELECT_MIN  = 2'd2;
    localparam logic [1:0] SELECT_HOUR = 2'd3;

    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  minute;
        logic [SEC_W-1:0]  second;
    } hms_t;

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned max);
        return (v >= max) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/timer_tick_gen.sv
// Clock prescaler: emits a one-cycle tick every Ticks enabled cycles, held at zero when
// disabled or cleared.
module timer_tick_gen #(
    parameter int unsigned Ticks = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned   CntW    = (Ticks > 1) ? $clog2(Ticks) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(Ticks - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i & ~clr_i & (cnt_q == CntLast);

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (!en_i || clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Settable hh:mm:ss countdown timer with expiry flag. Define TIMER_RELOAD_EN for a
// repeating timer that reloads from the last edited value and pulses out on expiry.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 100000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        select,
    input  logic              increment,
    output logic [SEC_W-1:0]  sec_out,
    output logic [MIN_W-1:0]  min_out,
    output logic [HOUR_W-1:0] hour_out,
    output logic              out
);

    hms_t time_q, time_d;
    logic out_q, out_d;
    logic inc_q;
    logic inc_edge;
    logic time_zero;
    logic tick;
`ifdef TIMER_RELOAD_EN
    hms_t preset_q, preset_d;
`endif

    assign inc_edge  = increment & ~inc_q;
    assign time_zero = (time_q == '0);

    timer_tick_gen #(
        .Ticks (TICKS_PER_SEC)
    ) u_tick_gen (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (enable),
        .clr_i  (time_zero),
        .tick_o (tick)
    );

    always_comb begin
        time_d = time_q;
`ifdef TIMER_RELOAD_EN
        out_d    = 1'b0;
        preset_d = preset_q;
`else
        out_d = out_q;
`endif
        if (!enable) begin
            if (inc_edge) begin
                case (select)
                    SELECT_SEC:  time_d.second = SEC_W'(wrap_inc(32'(time_q.second), 32'(SEC_MAX)));
                    SELECT_MIN:  time_d.minute = MIN_W'(wrap_inc(32'(time_q.minute), 32'(MIN_MAX)));
                    SELECT_HOUR: time_d.hour   = HOUR_W'(wrap_inc(32'(time_q.hour), 32'(HOUR_MAX)));
                    default:     ;
                endcase
                out_d = 1'b0;
`ifdef TIMER_RELOAD_EN
                preset_d = time_d;
`endif
            end
        end else if (tick) begin
            // tick never fires at 00:00:00, so the final branch always has hour > 0
            if (time_q.second != '0) begin
                time_d.second = time_q.second - 6'd1;
            end else if (time_q.minute != '0) begin
                time_d.second = SEC_MAX;
                time_d.minute = time_q.minute - 6'd1;
            end else begin
                time_d.second = SEC_MAX;
                time_d.minute = MIN_MAX;
                time_d.hour   = time_q.hour - 5'd1;
            end
            if (time_d == '0) begin
                out_d = 1'b1;
`ifdef TIMER_RELOAD_EN
                time_d = preset_q;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            time_q <= '0;
            out_q  <= 1'b0;
            inc_q  <= 1'b0;
        end else begin
            time_q <= time_d;
            out_q  <= out_d;
            inc_q  <= increment;
        end
    end

`ifdef TIMER_RELOAD_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            preset_q <= '0;
        end else begin
            preset_q <= preset_d;
        end
    end
`endif

    assign sec_out  = time_q.second;
    assign min_out  = time_q.minute;
    assign hour_out = time_q.hour;
    assign out      = out_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Randomised self-checking bench for countdown_timer against a seconds-total reference model.
module tb_countdown_timer;

    localparam int unsigned T = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] select = 2'd0;
    logic       increment = 1'b0;
    logic [5:0] sec_out;
    logic [5:0] min_out;
    logic [4:0] hour_out;
    logic       out;

    countdown_timer #(
        .TICKS_PER_SEC (T)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .select    (select),
        .increment (increment),
        .sec_out   (sec_out),
        .min_out   (min_out),
        .hour_out  (hour_out),
        .out       (out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: wall-clock fields, expiry flag, cycles spent in the current second.
    int m_h, m_m, m_s, m_phase;
    int p_h, p_m, p_s;
    bit m_out, m_inc_prev;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_h = 0; m_m = 0; m_s = 0; m_phase = 0;
        p_h = 0; p_m = 0; p_s = 0;
        m_out = 0; m_inc_prev = 0;
    endtask

    task automatic model_cycle();
        int  total;
        int  preset_total;
        bit  edge_seen;
        edge_seen  = increment && !m_inc_prev;
        m_inc_prev = increment;
`ifdef TIMER_RELOAD_EN
        m_out = 0;
`endif
        total        = m_h * 3600 + m_m * 60 + m_s;
        preset_total = p_h * 3600 + p_m * 60 + p_s;
        if (!enable) begin
            m_phase = 0;
            if (edge_seen) begin
                case (select)
                    2'd1:    m_s = (m_s + 1) % 60;
                    2'd2:    m_m = (m_m + 1) % 60;
                    2'd3:    m_h = (m_h + 1) % 24;
                    default: ;
                endcase
                m_out = 0;
                p_h = m_h; p_m = m_m; p_s = m_s;
            end
        end else if (total == 0) begin
            m_phase = 0;
        end else if (m_phase < int'(T) - 1) begin
            m_phase++;
        end else begin
            m_phase = 0;
            total--;
            if (total == 0) begin
                m_out = 1;
`ifdef TIMER_RELOAD_EN
                total = preset_total;
`endif
            end
            m_h = total / 3600;
            m_m = (total / 60) % 60;
            m_s = total % 60;
        end
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
        check_eq("sec", 32'(sec_out), 32'(m_s));
        check_eq("min", 32'(min_out), 32'(m_m));
        check_eq("hour", 32'(hour_out), 32'(m_h));
        check_eq("out", 32'(out), 32'(m_out));
    endtask

    task automatic pulse(input logic [1:0] sel);
        select    = sel;
        increment = 1'b1;
        step();
        increment = 1'b0;
        step();
    endtask

    initial begin
        int w;
        model_reset();
        #12;
        check_eq("rst_sec", 32'(sec_out), 0);
        check_eq("rst_min", 32'(min_out), 0);
        check_eq("rst_hour", 32'(hour_out), 0);
        check_eq("rst_out", 32'(out), 0);
        @(negedge clk);
        reset = 1'b1;

        // Editing while stopped
        pulse(2'd0);
        check_eq("none_sec", 32'(sec_out), 0);
        select    = 2'd1;
        increment = 1'b1;
        repeat (5) step();
        increment = 1'b0;
        step();
        check_eq("hold_sec", 32'(sec_out), 1);
        pulse(2'd1);
        check_eq("sec2", 32'(sec_out), 2);

        // Countdown from 2 s with one tick every T cycles
        enable = 1'b1;
        step();
        step();
        check_eq("dec_sec1", 32'(sec_out), 1);
        step();
        step();
`ifdef TIMER_RELOAD_EN
        check_eq("reload_sec", 32'(sec_out), 2);
        check_eq("reload_out", 32'(out), 1);
        step();
        check_eq("pulse_end", 32'(out), 0);
`else
        check_eq("expire_sec", 32'(sec_out), 0);
        check_eq("expire_out", 32'(out), 1);
`endif
        repeat (4) begin
            increment = ~increment;
            step();
        end
`ifndef TIMER_RELOAD_EN
        check_eq("hold_zero_sec", 32'(sec_out), 0);
        check_eq("hold_out", 32'(out), 1);
`endif
        enable = 1'b0;
        step();
        pulse(2'd2);
        check_eq("edit_min", 32'(min_out), 1);
        check_eq("edit_clr_out", 32'(out), 0);

        // Asynchronous reset in the middle of a count
        enable = 1'b1;
        repeat (3) step();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_eq("arst_sec", 32'(sec_out), 0);
        check_eq("arst_min", 32'(min_out), 0);
        check_eq("arst_out", 32'(out), 0);
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Borrow across all fields, then field wraps without carry
        pulse(2'd3);
        enable = 1'b1;
        step();
        step();
        check_eq("borrow_hour", 32'(hour_out), 0);
        check_eq("borrow_min", 32'(min_out), 59);
        check_eq("borrow_sec", 32'(sec_out), 59);
        enable = 1'b0;
        step();
        pulse(2'd1);
        check_eq("wrap_sec", 32'(sec_out), 0);
        check_eq("wrap_nocarry", 32'(min_out), 59);
        repeat (23) pulse(2'd3);
        check_eq("hour23", 32'(hour_out), 23);
        pulse(2'd3);
        check_eq("hour_wrap", 32'(hour_out), 0);

        // Randomised edit / run phases
        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(3) == 0) begin
                reset = 1'b0;
                model_reset();
                @(negedge clk);
                reset = 1'b1;
            end
            enable = 1'b0;
            repeat ($urandom_range(12, 2)) begin
                w = int'($urandom_range(18));
                select    = (w < 12) ? 2'd1 : (w < 15) ? 2'd2 : (w < 18) ? 2'd0 : 2'd3;
                increment = 1'($urandom_range(1));
                step();
            end
            enable = 1'b1;
            repeat ($urandom_range(150, 1)) begin
                increment = 1'($urandom_range(1));
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Settable hours:minutes:seconds countdown timer for the digital-clock design.
- While stopped, the user selects a field and bumps it with an increment input.
- While enabled, the count decrements once per second, derived from a clock prescaler.
- On reaching 00:00:00 the block raises `out` as the alarm/expired indication.

Parameters:
- TICKS_PER_SEC, default 100000000: clock cycles per one-second tick. Minimum 1. Benches use 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  1 = run (count down), 0 = stopped/edit mode.
- select  input  2  field to edit: SELECT_NONE=0, SELECT_SEC=1, SELECT_MIN=2, SELECT_HOUR=3.
- increment  input  1  synchronous level; each rising edge (0->1) bumps the selected field.
- sec_out  output  6  seconds, range 0..59.
- min_out  output  6  minutes, range 0..59.
- hour_out  output  5  hours, range 0..23.
- out  output  1  expired flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - sec/min/hour = 0, out = 0, prescaler = 0, increment edge register = 0.
- Edge detection:
  - inc_d is the registered copy of increment.
  - inc_edge = increment & ~inc_d, one cycle wide.
- Edit path (enable=0, inc_edge=1), applied on the next clock edge:
  - SELECT_SEC: sec = (sec==59) ? 0 : sec+1.
  - SELECT_MIN: min wraps 59->0 the same way.
  - SELECT_HOUR: hour wraps 23->0.
  - SELECT_NONE: no change.
  - No carry between fields.
  - Any edit clears out.
- While enable=1, inc_edge is ignored.
- Prescaler:
  - Held at 0 when enable=0 or time==00:00:00.
  - Otherwise counts 0..TICKS_PER_SEC-1.
  - tick=1 in the cycle when prescaler==TICKS_PER_SEC-1; the prescaler then returns to 0.
  - The first decrement therefore occurs TICKS_PER_SEC cycles after enable rises.
- Countdown on tick:
  - If sec>0: sec-1.
  - Else if min>0: sec=59, min-1.
  - Else if hour>0: sec=59, min=59, hour-1.
  - The tick that produces 00:00:00 also sets out=1 in the same clock edge.
- Expired state:
  - out stays 1 until reset or an edit increment.
  - Dropping enable does not clear out.
  - Counting halts at zero; no underflow.
- Enabling with time already 00:00:00 does nothing: out stays at its current value and no tick is generated.
- Fields never leave their legal range; outputs are registered directly (zero combinational output latency).

Optional Feature:
- Macro TIMER_RELOAD_EN.
- Defined:
  - Preset registers capture sec/min/hour on every edit.
  - On expiry, out pulses for exactly one cycle.
  - The count reloads from the preset on the same edge and keeps counting while enable=1 (repeating timer).
  - Reset clears the presets to 0; a zero preset does not reload.
- Undefined:
  - Latched `out`, halt at zero, as described above.
  - No preset registers.

Decomposition:
- Shared package/header for the clock design:
  - SELECT_NONE/SEC/MIN/HOUR codes (2-bit).
  - SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - Field width constants 6/6/5.
- One natural sub-module: timer_tick_gen.
  - Parameterised prescaler with enable and clear.
  - Outputs a one-cycle tick.
- Edit/countdown logic stays in countdown_timer.

Test Plan:
- Reset low mid-count -> all outputs 0 immediately (asynchronous), prescaler restarts after release.
- enable=0, select=SELECT_NONE, pulse increment -> 00:00:00 unchanged; select=SELECT_SEC, pulse -> sec=1; hold increment high 5 cycles -> only one bump.
- TICKS_PER_SEC=2, sec=2, enable=1 -> sec 1 after 2 cycles, 0 after 4 cycles, out=1 on that edge; counting stops and out stays 1; increment pulses while enabled ignored.
- Edit hour=1 (min=0, sec=0), enable=1 -> 00:59:59 after first tick; sec 59 edited +1 -> 0 with no min carry; hour 23 +1 -> 0.
- With out=1, enable=0, SELECT_MIN increment -> min=1, out=0.
- TIMER_RELOAD_EN, preset sec=2, enable=1 -> out single-cycle pulse every 4 cycles, sec sequence 2,1,0->2...
